// File: rtl/fpu_arbiter_if.sv
// Bundles the two requester ports, the fpu-side wiring and the response port of
// fpu_arbiter. The arbiter connects through the slave modport; its environment
// connects through the master modport.
interface fpu_arbiter_if #(
  parameter int unsigned TAG_W = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [31:0]      req0_a;
  logic [31:0]      req0_b;
  logic [1:0]       req0_sel;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [31:0]      req1_a;
  logic [31:0]      req1_b;
  logic [1:0]       req1_sel;
  logic [TAG_W-1:0] req1_tag;

  logic [31:0]      fpu_a;
  logic [31:0]      fpu_b;
  logic [1:0]       fpu_sel;
  logic [31:0]      fpu_y;
  logic             fpu_err;
  logic             fpu_overflow;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_src;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      rsp_y;
  logic             rsp_err;
  logic             rsp_overflow;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel, req0_tag,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_sel, req1_tag,
    output req1_ready,
    output fpu_a, fpu_b, fpu_sel,
    input  fpu_y, fpu_err, fpu_overflow,
    output rsp_valid, rsp_src, rsp_tag, rsp_y, rsp_err, rsp_overflow,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel, req0_tag,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_sel, req1_tag,
    input  req1_ready,
    input  fpu_a, fpu_b, fpu_sel,
    output fpu_y, fpu_err, fpu_overflow,
    input  rsp_valid, rsp_src, rsp_tag, rsp_y, rsp_err, rsp_overflow,
    output rsp_ready
  );
endinterface

// File: rtl/fpu_arbiter.sv
// Shares one fixed-latency fpu between two requesters. Ops are issued into the
// fpu operand registers, their owner rides a tag pipe matching the fpu latency,
// and results drain through a first-word-fall-through FIFO. A credit counter
// (ops in the tag pipe plus FIFO entries) stops issue before the FIFO can fill.
// Optional macro FPU_ARB_FIXED_PRIO_EN: req0 always wins ties (no rr pointer).
module fpu_arbiter #(
  parameter int unsigned FPU_LAT    = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_W      = 4
) (
  input logic           clk,
  input logic           rst,
  fpu_arbiter_if.slave  bus
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned FillW = PtrW + 1;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic             src;
    logic [TAG_W-1:0] tag;
    logic [31:0]      y;
    logic             err;
    logic             ovf;
  } rsp_t;

  typedef struct packed {
    logic             vld;
    logic             src;
    logic [TAG_W-1:0] tag;
  } tag_t;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             issue_ok, gnt0, gnt1, issue, push, pop, rsp_valid;
  logic [31:0]      fpu_a_q, fpu_b_q;
  logic [1:0]       fpu_sel_q;
  tag_t             pipe_q [FPU_LAT];
  rsp_t             mem_q  [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FillW-1:0] fill_q, fill_d;
  rsp_t             head;

  assign issue_ok = (cnt_q < CntW'(FIFO_DEPTH));

`ifndef FPU_ARB_FIXED_PRIO_EN
  logic rr_q;  // 1: req1 wins the next tie

  // Round-robin pointer moves to the requester that did not win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else if (issue) begin
      rr_q <= gnt0;
    end
  end
`endif

  // Combinational grant, gated by available credits.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (issue_ok) begin
      if (bus.req0_valid && bus.req1_valid) begin
`ifdef FPU_ARB_FIXED_PRIO_EN
        gnt0 = 1'b1;
`else
        gnt0 = ~rr_q;
        gnt1 = rr_q;
`endif
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  assign issue          = gnt0 | gnt1;
  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  // Operand registers feeding the fpu; hold when nothing issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpu_a_q   <= '0;
      fpu_b_q   <= '0;
      fpu_sel_q <= '0;
    end else if (issue) begin
      fpu_a_q   <= gnt1 ? bus.req1_a   : bus.req0_a;
      fpu_b_q   <= gnt1 ? bus.req1_b   : bus.req0_b;
      fpu_sel_q <= gnt1 ? bus.req1_sel : bus.req0_sel;
    end
  end

  assign bus.fpu_a   = fpu_a_q;
  assign bus.fpu_b   = fpu_b_q;
  assign bus.fpu_sel = fpu_sel_q;

  // Tag pipe: owner of each in-flight op, aligned with the fpu latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FPU_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= {issue, gnt1, (gnt1 ? bus.req1_tag : bus.req0_tag)};
      for (int i = 1; i < FPU_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // The last stage marks the cycle in which fpu_y belongs to that op.
  assign push      = pipe_q[FPU_LAT-1].vld;
  assign rsp_valid = (fill_q != '0);
  assign pop       = rsp_valid & bus.rsp_ready;
  assign fill_d    = fill_q + FillW'(push) - FillW'(pop);

  // Result FIFO; credits guarantee a push never meets a full FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= '{src: pipe_q[FPU_LAT-1].src, tag: pipe_q[FPU_LAT-1].tag,
                             y: bus.fpu_y, err: bus.fpu_err, ovf: bus.fpu_overflow};
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      fill_q <= fill_d;
    end
  end

  assign cnt_d = cnt_q + CntW'(issue) - CntW'(pop);

  // Credit counter: ops in the tag pipe plus ops waiting in the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign head             = mem_q[rd_ptr_q];
  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_src      = head.src;
  assign bus.rsp_tag      = head.tag;
  assign bus.rsp_y        = head.y;
  assign bus.rsp_err      = head.err;
  assign bus.rsp_overflow = head.ovf;

endmodule
